// File: rtl/hazard3_instr_compress_packer.sv
// Re-encodes RV32I instructions to RV32C where an exact equivalent exists and
// packs the halfword stream little-endian into 32-bit words.
module hazard3_instr_compress_packer #(
   parameter int EXTENSION_C   = 1,
   parameter int EXTENSION_ZCB = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        idle,
   output logic        in_was_compressed
);

   function automatic logic is_c(input logic [4:0] r);
      return r[4:3] == 2'b01;
   endfunction

   function automatic logic fits6(input logic [11:0] v);
      return v[11:5] == {7{v[5]}};
   endfunction

   // Returns {ok, c16}; ok=0 means the instruction must stay 32 bits wide.
   function automatic logic [16:0] compress(input logic [31:0] ins);
      logic [6:0]  opc;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] immi, imms;
      logic [12:1] immb;
      logic [20:1] immj;
      logic [10:0] jf;
      logic [1:0]  aop;
      logic        ok;
      logic [15:0] c;
      opc  = ins[6:0];
      rd   = ins[11:7];
      f3   = ins[14:12];
      rs1  = ins[19:15];
      rs2  = ins[24:20];
      f7   = ins[31:25];
      immi = ins[31:20];
      imms = {ins[31:25], ins[11:7]};
      immb = {ins[31], ins[7], ins[30:25], ins[11:8]};
      immj = {ins[31], ins[19:12], ins[20], ins[30:21]};
      jf   = {immj[11], immj[4], immj[9:8], immj[10], immj[6], immj[7], immj[3:1], immj[5]};
      aop  = 2'b00;
      ok   = 1'b0;
      c    = 16'h0000;
      case (opc)
         7'b0010011: begin
            case (f3)
               3'b000: begin
                  if (rd == 5'd0 && rs1 == 5'd0 && immi == 12'd0) begin
                     ok = 1'b1; c = 16'h0001;
                  end else if (rd != 5'd0 && rd == rs1 && immi != 12'd0 && fits6(immi)) begin
                     ok = 1'b1; c = {3'b000, immi[5], rd, immi[4:0], 2'b01};
                  end else if (rd != 5'd0 && rs1 == 5'd0 && fits6(immi)) begin
                     ok = 1'b1; c = {3'b010, immi[5], rd, immi[4:0], 2'b01};
                  end else if (rd == 5'd2 && rs1 == 5'd2 && immi != 12'd0 && immi[3:0] == 4'd0
                               && immi[11:9] == {3{immi[9]}}) begin
                     ok = 1'b1;
                     c  = {3'b011, immi[9], 5'd2, immi[4], immi[6], immi[8:7], immi[5], 2'b01};
                  end else if (rs1 == 5'd2 && is_c(rd) && immi != 12'd0 && immi[11:10] == 2'd0
                               && immi[1:0] == 2'd0) begin
                     ok = 1'b1;
                     c  = {3'b000, immi[5:4], immi[9:6], immi[2], immi[3], rd[2:0], 2'b00};
                  end
               end
               3'b001: begin
                  if (f7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                     ok = 1'b1; c = {4'b0000, rd, rs2, 2'b10};
                  end
               end
               3'b101: begin
                  if (rd == rs1 && is_c(rd) && rs2 != 5'd0 && (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
                     ok = 1'b1; c = {4'b1000, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
                  end
               end
               3'b111: begin
                  if (rd == rs1 && is_c(rd) && fits6(immi)) begin
                     ok = 1'b1; c = {3'b100, immi[5], 2'b10, rd[2:0], immi[4:0], 2'b01};
                  end else if (EXTENSION_ZCB != 0 && rd == rs1 && is_c(rd) && immi == 12'h0ff) begin
                     ok = 1'b1; c = {6'b100111, rd[2:0], 2'b11, 3'b000, 2'b01};
                  end
               end
               3'b100: begin
                  if (EXTENSION_ZCB != 0 && rd == rs1 && is_c(rd) && immi == 12'hfff) begin
                     ok = 1'b1; c = {6'b100111, rd[2:0], 2'b11, 3'b101, 2'b01};
                  end
               end
               default: ;
            endcase
         end
         7'b0110111: begin
            if (rd != 5'd0 && rd != 5'd2 && ins[31:12] != 20'd0 && ins[31:17] == {15{ins[17]}}) begin
               ok = 1'b1; c = {3'b011, ins[17], rd, ins[16:12], 2'b01};
            end
         end
         7'b0110011: begin
            if (f7 == 7'd0 && f3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0) begin
               if (rs1 == 5'd0) begin
                  ok = 1'b1; c = {4'b1000, rd, rs2, 2'b10};
               end else if (rs1 == rd) begin
                  ok = 1'b1; c = {4'b1001, rd, rs2, 2'b10};
               end
            end else if (rd == rs1 && is_c(rd) && is_c(rs2)) begin
               if (f7 == 7'b0100000 && f3 == 3'b000) begin
                  ok = 1'b1; aop = 2'b00;
               end else if (f7 == 7'd0 && f3 == 3'b100) begin
                  ok = 1'b1; aop = 2'b01;
               end else if (f7 == 7'd0 && f3 == 3'b110) begin
                  ok = 1'b1; aop = 2'b10;
               end else if (f7 == 7'd0 && f3 == 3'b111) begin
                  ok = 1'b1; aop = 2'b11;
               end
               c = {6'b100011, rd[2:0], aop, rs2[2:0], 2'b01};
            end
         end
         7'b0000011: begin
            if (f3 == 3'b010 && immi[1:0] == 2'd0) begin
               if (is_c(rd) && is_c(rs1) && immi[11:7] == 5'd0) begin
                  ok = 1'b1;
                  c  = {3'b010, immi[5:3], rs1[2:0], immi[2], immi[6], rd[2:0], 2'b00};
               end else if (rs1 == 5'd2 && rd != 5'd0 && immi[11:8] == 4'd0) begin
                  ok = 1'b1; c = {3'b010, immi[5], rd, immi[4:2], immi[7:6], 2'b10};
               end
            end
         end
         7'b0100011: begin
            if (f3 == 3'b010 && imms[1:0] == 2'd0) begin
               if (is_c(rs2) && is_c(rs1) && imms[11:7] == 5'd0) begin
                  ok = 1'b1;
                  c  = {3'b110, imms[5:3], rs1[2:0], imms[2], imms[6], rs2[2:0], 2'b00};
               end else if (rs1 == 5'd2 && imms[11:8] == 4'd0) begin
                  ok = 1'b1; c = {3'b110, imms[5:2], imms[7:6], rs2, 2'b10};
               end
            end
         end
         7'b1101111: begin
            if (immj[20:11] == {10{immj[11]}} && (rd == 5'd0 || rd == 5'd1)) begin
               ok = 1'b1; c = {~rd[0], 2'b01, jf, 2'b01};
            end
         end
         7'b1100111: begin
            if (f3 == 3'b000 && immi == 12'd0 && rs1 != 5'd0 && (rd == 5'd0 || rd == 5'd1)) begin
               ok = 1'b1; c = {3'b100, rd[0], rs1, 5'd0, 2'b10};
            end
         end
         7'b1100011: begin
            if ((f3 == 3'b000 || f3 == 3'b001) && rs2 == 5'd0 && is_c(rs1)
                && immb[12:8] == {5{immb[8]}}) begin
               ok = 1'b1;
               c  = {2'b11, f3[0], immb[8], immb[4:3], rs1[2:0], immb[7:6], immb[2:1], immb[5], 2'b01};
            end
         end
         7'b1110011: begin
            if (ins == 32'h0010_0073) begin
               ok = 1'b1; c = 16'h9002;
            end
         end
         default: ;
      endcase
      return {ok, c};
   endfunction

   logic [16:0] comp;
   logic        c_ok;
   logic [15:0] c16;
   logic        slot_free, in_fire;

   logic [15:0] hold_q, hold_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        was_c_q, was_c_d;

   assign comp      = compress(in_instr);
   assign c_ok      = (EXTENSION_C != 0) && comp[16];
   assign c16       = comp[15:0];
   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = !flush && slot_free;
   assign in_fire   = in_valid && in_ready;

   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q && !out_ready;
      was_c_d      = 1'b0;
      if (in_fire) begin
         was_c_d = c_ok;
         if (c_ok && !hold_valid_q) begin
            hold_d       = c16;
            hold_valid_d = 1'b1;
         end else if (c_ok) begin
            out_data_d   = {c16, hold_q};
            out_valid_d  = 1'b1;
            hold_valid_d = 1'b0;
         end else if (!hold_valid_q) begin
            out_data_d  = in_instr;
            out_valid_d = 1'b1;
         end else begin
            // A 32-bit instruction straddles the word boundary; its upper half stays held.
            out_data_d  = {in_instr[15:0], hold_q};
            out_valid_d = 1'b1;
            hold_d      = in_instr[31:16];
         end
      end else if (flush && hold_valid_q && slot_free) begin
         out_data_d   = {16'h0001, hold_q};
         out_valid_d  = 1'b1;
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q       <= 16'h0000;
         hold_valid_q <= 1'b0;
         out_data_q   <= 32'h0000_0000;
         out_valid_q  <= 1'b0;
         was_c_q      <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         was_c_q      <= was_c_d;
      end
   end

   assign out_valid         = out_valid_q;
   assign out_data          = out_data_q;
   assign idle              = !hold_valid_q && !out_valid_q;
   assign in_was_compressed = was_c_q;

endmodule

// File: tb/tb_hazard3_instr_compress_packer.sv
// Directed bench for the compress packer: one compressing instance and one
// passthrough instance share the stimulus.
module tb_hazard3_instr_compress_packer;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, out_ready;
   logic [31:0] in_instr;
   logic        in_ready, out_valid, idle, in_was_compressed;
   logic [31:0] out_data;
   logic        nc_in_ready, nc_out_valid, nc_idle, nc_in_was_compressed;
   logic [31:0] nc_out_data;
   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] pa [5];
   logic [31:0] pb [5];
   logic [31:0] pw [5];
   logic [31:0] pt [3];

   always #5 clk = ~clk;

   hazard3_instr_compress_packer #(.EXTENSION_C(1), .EXTENSION_ZCB(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .idle(idle), .in_was_compressed(in_was_compressed)
   );

   hazard3_instr_compress_packer #(.EXTENSION_C(0), .EXTENSION_ZCB(0)) dut_nc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready),
      .in_instr(in_instr), .flush(flush), .out_valid(nc_out_valid), .out_ready(out_ready),
      .out_data(nc_out_data), .idle(nc_idle), .in_was_compressed(nc_in_was_compressed)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] ins);
      in_instr = ins;
      in_valid = 1'b1;
      #1;
      check("push_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      pa[0] = 32'h0000_0013; pb[0] = 32'hfff0_0513; pw[0] = 32'h557d_0001; // nop, li x10,-1
      pa[1] = 32'h0010_0073; pb[1] = 32'h0000_8067; pw[1] = 32'h8082_9002; // ebreak, ret
      pa[2] = 32'h0044_a403; pb[2] = 32'h0081_2023; pw[2] = 32'hc022_40c0; // lw, swsp
      pa[3] = 32'h0004_0463; pb[3] = 32'h0025_1513; pw[3] = 32'h050a_c401; // beqz, slli
      pa[4] = 32'h4094_0433; pb[4] = 32'hffff_f06f; pw[4] = 32'hbffd_8c05; // sub, j -2
      pt[0] = 32'h0004_0413; pt[1] = 32'h0804_a403; pt[2] = 32'h1004_8063;

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = 32'h0;
      tick(); tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_idle", {31'd0, idle}, 32'd1);
      check("rst_wc", {31'd0, in_was_compressed}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      // compressed, straddling 32-bit, compressed
      push(32'h0014_0413);
      check("t1_no_out", {31'd0, out_valid}, 32'd0);
      check("t1_idle", {31'd0, idle}, 32'd0);
      check("t1_wc", {31'd0, in_was_compressed}, 32'd1);
      push(32'h1234_52b7);
      check("t1b_valid", {31'd0, out_valid}, 32'd1);
      check("t1b_data", out_data, 32'h52b7_0405);
      check("t1b_wc", {31'd0, in_was_compressed}, 32'd0);
      push(32'h00b0_0533);
      check("t1c_data", out_data, 32'h852e_1234);
      check("t1c_wc", {31'd0, in_was_compressed}, 32'd1);
      tick();
      check("t1_drain_idle", {31'd0, idle}, 32'd1);
      check("t1_drain_valid", {31'd0, out_valid}, 32'd0);

      // flush pads with c.nop
      push(32'h0014_0413);
      flush = 1'b1;
      #1;
      check("fl_in_ready0", {31'd0, in_ready}, 32'd0);
      tick();
      check("fl_valid", {31'd0, out_valid}, 32'd1);
      check("fl_data", out_data, 32'h0001_0405);
      check("fl_in_ready1", {31'd0, in_ready}, 32'd0);
      tick();
      check("fl_idle", {31'd0, idle}, 32'd1);
      check("fl_in_ready2", {31'd0, in_ready}, 32'd0);
      flush = 1'b0;

      for (int i = 0; i < 3; i++) begin
         push(pt[i]);
         check("pt_valid", {31'd0, out_valid}, 32'd1);
         check("pt_data", out_data, pt[i]);
         check("pt_wc", {31'd0, in_was_compressed}, 32'd0);
      end
      tick();
      check("pt_idle", {31'd0, idle}, 32'd1);

      for (int i = 0; i < 5; i++) begin
         push(pa[i]);
         check("pair_first_wc", {31'd0, in_was_compressed}, 32'd1);
         check("pair_first_noout", {31'd0, out_valid}, 32'd0);
         push(pb[i]);
         check("pair_data", out_data, pw[i]);
         check("pair_second_wc", {31'd0, in_was_compressed}, 32'd1);
      end
      tick();
      check("pair_idle", {31'd0, idle}, 32'd1);

      // output stall with three words queued
      out_ready = 1'b0;
      push(pt[1]);
      check("st_data0", out_data, pt[1]);
      in_instr = pt[2];
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("st_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
         check("st_hold_data", out_data, pt[1]);
         check("st_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check("st_release_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      check("st_drain_b", out_data, pt[2]);
      in_instr = pt[0];
      tick();
      check("st_drain_c", out_data, pt[0]);
      in_valid = 1'b0;
      tick();
      check("st_drain_done", {31'd0, out_valid}, 32'd0);

      // reset while stalled with a pending halfword and full output slot
      out_ready = 1'b0;
      push(32'h0014_0413);
      push(32'h1234_52b7);
      check("mr_pre_data", out_data, 32'h52b7_0405);
      check("mr_pre_idle", {31'd0, idle}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_valid", {31'd0, out_valid}, 32'd0);
      check("mr_idle", {31'd0, idle}, 32'd1);
      check("mr_data", out_data, 32'd0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      check("mr_no_pad", {31'd0, out_valid}, 32'd0);
      check("mr_idle2", {31'd0, idle}, 32'd1);
      flush = 1'b0;

      // passthrough instance
      push(32'h0014_0413);
      check("nc_data0", nc_out_data, 32'h0014_0413);
      check("nc_valid0", {31'd0, nc_out_valid}, 32'd1);
      check("nc_wc0", {31'd0, nc_in_was_compressed}, 32'd0);
      tick();
      check("nc_idle0", {31'd0, nc_idle}, 32'd1);
      push(32'h00b0_0533);
      check("nc_data1", nc_out_data, 32'h00b0_0533);
      check("c_pair_word", out_data, 32'h852e_0405);
      flush = 1'b1;
      #1;
      check("nc_fl_rdy", {31'd0, nc_in_ready}, 32'd0);
      tick();
      check("nc_fl_idle", {31'd0, nc_idle}, 32'd1);
      check("nc_fl_valid", {31'd0, nc_out_valid}, 32'd0);
      flush = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard3_instr_compress_packer.md
Name: hazard3_instr_compress_packer

Overview:
- Encoder-side counterpart of the instruction decompressor.
- Accepts a stream of 32-bit RV32I instructions.
- Re-encodes each instruction to its RV32C 16-bit form when an exactly equivalent encoding exists.
- Packs the resulting halfword stream little-endian into 32-bit output words.
- Used to build compressed code images for the debug program buffer and boot-ROM generation. A valid/ready interface sits on each side.

Parameters:
- EXTENSION_C, 1, if 0 no instruction is ever compressed: pure 32-bit passthrough, hold register always empty.
- EXTENSION_ZCB, 0, if 1 also emit c.zext.b (andi rd',rd',0xff) and c.not (xori rd',rd',-1).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_instr valid
- in_ready  output  1  packer accepts in_instr this cycle
- in_instr  input  32  RV32I instruction; in_instr[1:0] must be 2'b11
- flush  input  1  level request: pad and emit any pending halfword
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  32  packed word; lower address halfword in [15:0]
- idle  output  1  no pending halfword and no valid output
- in_was_compressed  output  1  pulses with each in_fire whose instruction was compressed

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_data=0, hold_valid=0, hold=0, in_was_compressed=0. Reset mid-sequence discards the pending halfword and output word. No padding is emitted.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = !flush & (!out_valid | out_ready). The output slot is one deep and registered, so there is no combinational path from in_valid to out_valid.
- Compression is combinational on in_instr. The result is registered at in_fire.
- Encodings:
  - Compress only to the standard RV32C encoding with identical semantics.
  - Never emit reserved or HINT encodings, e.g. addi rd!=0 with imm=0, li x0, lui x0.
  - Covered set:
    - c.nop (addi x0,x0,0)
    - c.addi: rd=rs1!=0, imm in [-32,31], imm!=0
    - c.li: rs1=x0, rd!=0
    - c.lui: rd∉{0,2}, imm!=0, sign-extended 6-bit
    - c.addi16sp / c.addi4spn
    - c.mv / c.add
    - c.sub/xor/or/and/andi/srli/srai with rd'=rs1' in x8-x15
    - c.slli: shamt!=0
    - c.lw/c.sw: rs1', rd'/rs2' in x8-x15, offset multiple of 4 in [0,124]
    - c.lwsp/c.swsp: offset multiple of 4 in [0,252]; lwsp needs rd!=0
    - c.j/c.jal: offset even in [-2048,2046]
    - c.jr/c.jalr: imm=0, rs1!=0, rd x0/x1 respectively
    - c.beqz/c.bnez: rs2=x0, rs1', offset even in [-256,254]
    - c.ebreak
  - Anything else passes through as 32 bits.
  - Branch/jump offsets are copied unchanged. Re-linking is the caller's responsibility.
- Packing at in_fire, given hold_valid (H) and compressed result (C):
  - C, !H: hold<=c16; H<=1; no output.
  - C, H: out_data<={c16,hold}; out_valid<=1; H<=0.
  - !C, !H: out_data<=in_instr; out_valid<=1.
  - !C, H: out_data<={in_instr[15:0],hold}; out_valid<=1; hold<=in_instr[31:16]; H stays 1.
- out_valid clears on out_fire unless reloaded in the same cycle. Back-to-back throughput is 1 word/cycle.
- Flush: while flush=1, input is stalled.
  - If H=1 and the output slot is free (or freeing): out_data<={16'h0001,hold} (c.nop pad); H<=0.
  - If H=0: no action.
  - idle = !H & !out_valid. The requester holds flush until idle=1.
- in_was_compressed is a registered 1-cycle pulse.
- Output-side stall (out_ready=0, out_valid=1) holds out_data stable and drops in_ready. hold is unchanged.

Test Plan:
- Reset, then addi x8,x8,1 (0x00140413) -> no output; idle=0; in_was_compressed pulses.
- Then lui x5,0x12345 (0x123452b7) -> out_data=0x52b70405; hold=0x1234.
- Then add x10,x0,x11 (0x00b00533) -> out_data=0x852e1234; idle=1 after out_fire.
- Single addi x8,x8,1, then flush=1 -> out_data=0x00010405; idle=1; in_ready=0 throughout flush.
- Non-encodable cases pass through unchanged as 32-bit words with no compression pulse:
  - addi x8,x8,0 (0x00040413, HINT)
  - lw x8,128(x9) (0x0804a403)
  - beq x9,x0,+256 (0x10048063)
- out_ready=0 for 5 cycles with 3 instructions queued -> out_data stable, in_ready=0, no data lost; words then drain in order. Assert rst_n mid-stall -> out_valid=0, idle=1 next cycle.
- EXTENSION_C=0 -> every instruction passes through; hold never valid; flush completes immediately.
